uart_tx_ctrl: RTL

- Synthesizable 8N1 UART transmitter with a small transmit FIFO.
- Drives the serial line that the testbench UART monitor samples (uart0_sout), so firmware output reaches the simulation log.
- Sits between the APB/bus-side write logic (wr_* handshake) and the pad-level serial output.
- Bit timing uses a 16x-oversample tick, the same tick convention the monitor uses.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_ctrl_if.sv | 12 +
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame constants and FSM states.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_OVERSAMPLE = 16;
    localparam logic UART_IDLE_LVL   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Bus-side byte write handshake into the UART transmitter.
interface uart_tx_ctrl_if;
    import uart_pkg::*;

    logic                      wr_vld;
    logic [UART_DATA_BITS-1:0] wr_data;
    logic                      wr_rdy;

    modport master (output wr_vld, output wr_data, input  wr_rdy);
    modport slave  (input  wr_vld, input  wr_data, output wr_rdy);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; the head word comes straight out of
// the storage flops so a pop can capture it on the same edge.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic             full_q;
    logic             do_push, do_pop;

    // A full FIFO refuses pushes even when a pop lands in the same cycle.
    assign do_push = push && !full_q;
    assign do_pop  = pop && (cnt_q != '0);
    assign cnt_nxt = cnt_q + CW'(do_push) - CW'(do_pop);

    assign rd_data = mem[rd_ptr];
    assign full    = full_q;
    assign empty   = (cnt_q == '0);
    assign cnt     = cnt_q;

    // Pointers wrap naturally at the power-of-two depth; full is precomputed.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt_q  <= cnt_nxt;
            full_q <= (cnt_nxt == CW'(DEPTH));
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// 8N1 UART transmitter: byte FIFO in front of a start/data/stop shifter timed
// by a 16x oversample tick derived from a programmable divisor.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int RST_DIV    = 324
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic                          div_ld,
    uart_tx_ctrl_if.slave                 wr,
    output logic                          sout,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int SUB_W = $clog2(UART_OVERSAMPLE);

    tx_state_e                 state, state_nxt;
    logic [DIV_WIDTH-1:0]      div_q, frame_div, tick_cnt;
    logic [SUB_W-1:0]          sub_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift_q, fifo_rd;
    logic                      tick, bit_end, pop, push;
    logic                      fifo_full, fifo_empty;
    logic                      sout_nxt;

    assign push      = wr.wr_vld && wr.wr_rdy;
    assign wr.wr_rdy = !fifo_full;
    assign tick      = (state != IDLE) && (tick_cnt == '0);
    assign bit_end   = tick && (sub_cnt == {SUB_W{1'b1}});
    assign tx_busy   = (state != IDLE) || (fifo_cnt != '0);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (push),
        .push_data (wr.wr_data),
        .pop       (pop),
        .rd_data   (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .cnt       (fifo_cnt)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and pop; STOP chains straight into START when bytes are waiting.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: if (bit_end) state_nxt = DATA;
            DATA:  if (bit_end && bit_idx == 3'(UART_DATA_BITS - 1)) state_nxt = STOP;
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Baud timing and data shifter; a pop starts a new frame with the latest divisor.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            div_q     <= DIV_WIDTH'(RST_DIV);
            frame_div <= DIV_WIDTH'(RST_DIV);
            tick_cnt  <= DIV_WIDTH'(RST_DIV);
            sub_cnt   <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
        end else begin
            if (div_ld) div_q <= baud_div;
            if (pop) begin
                frame_div <= div_q;
                tick_cnt  <= div_q;
                sub_cnt   <= '0;
                bit_idx   <= '0;
                shift_q   <= fifo_rd;
            end else begin
                if (state == IDLE || tick) tick_cnt <= frame_div;
                else                       tick_cnt <= tick_cnt - 1'b1;
                if (tick) sub_cnt <= sub_cnt + 1'b1;
                if (state == DATA && bit_end) begin
                    shift_q <= shift_q >> 1;
                    bit_idx <= bit_idx + 1'b1;
                end
            end
        end
    end

    // Line level for the current state; registered so the pad never glitches.
    always_comb begin
        sout_nxt = UART_IDLE_LVL;
        case (state)
            START:   sout_nxt = 1'b0;
            DATA:    sout_nxt = shift_q[0];
            default: sout_nxt = UART_IDLE_LVL;
        endcase
    end

    // Serial output flop; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) sout <= UART_IDLE_LVL;
        else        sout <= sout_nxt;
    end

endmodule
